// File: rtl/port_bank_pkg.sv
//==============================================================================
// Module      : port_bank_pkg
// Description : Shared constants and types for the CPU I/O port bank: default
//               sizing, port-map bases and the auto-scan select code.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package port_bank_pkg;

    // Default sizing of the port bank
    localparam int c_WORD_SIZE = 16;
    localparam int c_NUM_OUT   = 4;
    localparam int c_NUM_IN    = 2;
    localparam int c_IN_WIDTH  = 4;
    localparam int c_SEL_W     = 3;
    localparam int c_DWELL     = 50000000;

    // Port map: output registers start at OUT_BASE, input channels follow them
    localparam int c_OUT_BASE  = 0;

    // Which kind of location a port address decodes to
    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_OUT  = 2'd1,
        SRC_IN   = 2'd2
    } rd_src_e;

    // The auto-scan display select code is the all-ones value of show_sel
    function automatic logic [31:0] sel_scan_code(input int unsigned sel_w);
        return (32'd1 << sel_w) - 32'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/port_bank_in_sync_edge.sv
//==============================================================================
// Module      : in_sync_edge
// Description : One input channel: 2-flop synchroniser per bit, rising-edge
//               detect on the synchronised level, and sticky edge bits that
//               are cleared on read with the new edge taking priority.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module in_sync_edge
    import port_bank_pkg::*;
#(
    parameter int IN_WIDTH = c_IN_WIDTH
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [IN_WIDTH-1:0] i_raw,
    input  logic                i_clr,
    output logic [IN_WIDTH-1:0] o_level,
    output logic [IN_WIDTH-1:0] o_sticky
);

    logic [IN_WIDTH-1:0] r_meta;
    logic [IN_WIDTH-1:0] r_sync;
    logic [IN_WIDTH-1:0] r_prev;
    logic [IN_WIDTH-1:0] r_sticky;
    logic [IN_WIDTH-1:0] w_rise;

    assign w_rise   = r_sync & ~r_prev;
    assign o_level  = r_sync;
    assign o_sticky = r_sticky;

    // Synchronise the raw inputs and remember the previous synchronised level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= '0;
            r_sync <= '0;
            r_prev <= '0;
        end else begin
            r_meta <= i_raw;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    // Sticky capture: a clear drops only the returned bits, a same-cycle edge survives
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sticky <= '0;
        end else if (i_clr) begin
            r_sticky <= w_rise;
        end else begin
            r_sticky <= r_sticky | w_rise;
        end
    end

endmodule

`default_nettype wire

// File: rtl/port_bank.sv
//==============================================================================
// Module      : port_bank
// Description : CPU I/O port block. NUM_OUT writable output registers and
//               NUM_IN synchronised input channels with sticky rising-edge
//               capture on the cpu port bus, plus the registered value/index
//               feeding the seven-segment display driver.
//               Build option: PORT_BANK_AUTOSCAN_EN enables display auto-scan
//               when show_sel is all-ones.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module port_bank
    import port_bank_pkg::*;
#(
    parameter int WORD_SIZE = c_WORD_SIZE,
    parameter int NUM_OUT   = c_NUM_OUT,
    parameter int NUM_IN    = c_NUM_IN,
    parameter int IN_WIDTH  = c_IN_WIDTH,
    parameter int SEL_W     = c_SEL_W,
    parameter int DWELL     = c_DWELL
) (
    input  logic                         mclk,
    input  logic                         rst_n,
    input  logic [WORD_SIZE-1:0]         portaddr,
    input  logic [WORD_SIZE-1:0]         portval,
    input  logic                         portset,
    input  logic                         portget,
    output logic [WORD_SIZE-1:0]         portout,
    output logic                         portready,
    input  logic [NUM_IN*IN_WIDTH-1:0]   in_raw,
    output logic [NUM_OUT*WORD_SIZE-1:0] out_flat,
    input  logic [SEL_W-1:0]             show_sel,
    output logic [WORD_SIZE-1:0]         show_val,
    output logic [SEL_W-1:0]             show_idx
);

    localparam logic [WORD_SIZE-1:0] c_IN_BASE = WORD_SIZE'(c_OUT_BASE + NUM_OUT);
    localparam logic [WORD_SIZE-1:0] c_IN_END  = WORD_SIZE'(c_OUT_BASE + NUM_OUT + NUM_IN);
    localparam int                   c_HALF    = WORD_SIZE / 2;

    logic [WORD_SIZE-1:0]       r_regs [NUM_OUT];
    logic [WORD_SIZE-1:0]       r_portout;
    logic                       r_portready;
    logic [WORD_SIZE-1:0]       r_show_val;
    logic [SEL_W-1:0]           r_show_idx;

    logic [NUM_IN*IN_WIDTH-1:0] w_level;
    logic [NUM_IN*IN_WIDTH-1:0] w_sticky;
    logic [NUM_IN-1:0]          w_clr;
    rd_src_e                    w_rd_src;
    logic [WORD_SIZE-1:0]       w_rd_data;
    logic [WORD_SIZE-1:0]       w_show_reg;

    assign portout   = r_portout;
    assign portready = r_portready;
    assign show_val  = r_show_val;
    assign show_idx  = r_show_idx;

    // Input channels, each with its own synchroniser and sticky edge bits
    generate
        for (genvar i = 0; i < NUM_IN; i++) begin : g_in
            in_sync_edge #(
                .IN_WIDTH (IN_WIDTH)
            ) u_in_sync_edge (
                .clk      (mclk),
                .rst_n    (rst_n),
                .i_raw    (in_raw[i*IN_WIDTH +: IN_WIDTH]),
                .i_clr    (w_clr[i]),
                .o_level  (w_level[i*IN_WIDTH +: IN_WIDTH]),
                .o_sticky (w_sticky[i*IN_WIDTH +: IN_WIDTH])
            );
        end
    endgenerate

    // Flatten the output registers for the rest of the system
    generate
        for (genvar k = 0; k < NUM_OUT; k++) begin : g_out
            assign out_flat[k*WORD_SIZE +: WORD_SIZE] = r_regs[k];
        end
    endgenerate

    // Read decode: select the read data and flag which input channel to clear
    always_comb begin
        w_rd_data = '0;
        w_clr     = '0;
        if (portaddr < c_IN_BASE) begin
            w_rd_src = SRC_OUT;
        end else if (portaddr < c_IN_END) begin
            w_rd_src = SRC_IN;
        end else begin
            w_rd_src = SRC_NONE;
        end
        case (w_rd_src)
            SRC_OUT: begin
                for (int k = 0; k < NUM_OUT; k++) begin
                    if (portaddr == WORD_SIZE'(c_OUT_BASE + k)) begin
                        w_rd_data = r_regs[k];
                    end
                end
            end
            SRC_IN: begin
                for (int i = 0; i < NUM_IN; i++) begin
                    if (portaddr == c_IN_BASE + WORD_SIZE'(i)) begin
                        w_rd_data[c_HALF +: IN_WIDTH] = w_sticky[i*IN_WIDTH +: IN_WIDTH];
                        w_rd_data[0 +: IN_WIDTH]      = w_level[i*IN_WIDTH +: IN_WIDTH];
                        w_clr[i]                      = portget;
                    end
                end
            end
            default: begin
                w_rd_data = '0;
            end
        endcase
    end

    // Output register writes; unmapped addresses are silently dropped
    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_OUT; k++) begin
                r_regs[k] <= '0;
            end
        end else if (portset) begin
            for (int k = 0; k < NUM_OUT; k++) begin
                if (portaddr == WORD_SIZE'(c_OUT_BASE + k)) begin
                    r_regs[k] <= portval;
                end
            end
        end
    end

    // One-cycle read: data is taken from pre-write state and held until the next read
    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            r_portout   <= '0;
            r_portready <= 1'b0;
        end else begin
            r_portready <= portget;
            if (portget) begin
                r_portout <= w_rd_data;
            end
        end
    end

    // Register addressed by the displayed index; out-of-range indices show zero
    always_comb begin
        w_show_reg = '0;
        for (int k = 0; k < NUM_OUT; k++) begin
            if (r_show_idx == SEL_W'(k)) begin
                w_show_reg = r_regs[k];
            end
        end
    end

`ifdef PORT_BANK_AUTOSCAN_EN
    localparam logic [SEL_W-1:0] c_SEL_SCAN = SEL_W'(sel_scan_code(SEL_W));
    localparam logic [SEL_W-1:0] c_IDX_LAST = SEL_W'(NUM_OUT - 1);
    localparam int               c_CNT_W    = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DWELL - 1);

    logic [c_CNT_W-1:0] r_scan_cnt;

    // Display select: follow show_sel, or step through the outputs every DWELL cycles
    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            r_scan_cnt <= '0;
            r_show_idx <= '0;
            r_show_val <= '0;
        end else begin
            if (show_sel == c_SEL_SCAN) begin
                if (r_scan_cnt == c_CNT_LAST) begin
                    r_scan_cnt <= '0;
                    r_show_idx <= (r_show_idx >= c_IDX_LAST) ? '0 : r_show_idx + 1'b1;
                end else begin
                    r_scan_cnt <= r_scan_cnt + 1'b1;
                end
            end else begin
                r_scan_cnt <= '0;
                r_show_idx <= show_sel;
            end
            r_show_val <= w_show_reg;
        end
    end
`else
    // Display select: follow show_sel directly, value lags the index by one cycle
    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            r_show_idx <= '0;
            r_show_val <= '0;
        end else begin
            r_show_idx <= show_sel;
            r_show_val <= w_show_reg;
        end
    end
`endif

endmodule

`default_nettype wire
